// File: rtl/prio_arbiter.sv
// Request arbiter with a registered, sticky grant and a valid/ready output handshake.
// Defining PRIO_ARB_RR_EN selects round-robin arbitration; without it, the highest-index request wins.
module prio_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         fsm_state
);

  // Handshake: a grant is offered while valid=1 and is consumed on any rising edge
  // where valid=1 and ready=1. The grant holds steady until it is consumed.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [W-1:0]   win;
  logic           handshake;

  assign handshake = (state_q == HOLD) && ready;

`ifdef PRIO_ARB_RR_EN
  logic [W-1:0] ptr;

  // Search downward from ptr, wrapping from 0 back to N-1.
  always_comb begin
    logic found;
    int   j;
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) - k;
      if (j < 0) j = j + N;
      if (!found && req[W'(j)]) begin
        win   = W'(j);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= W'(N - 1);
    end else if (handshake) begin
      ptr <= (idx_q == '0) ? W'(N - 1) : idx_q - W'(1);
    end
  end
`else
  // The ascending scan lets the highest set bit overwrite any lower one.
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[W'(i)]) win = W'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    valid     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    fsm_state = state_q;
    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          state_d = HOLD;
          idx_d   = win;
        end
      end
      HOLD: begin
        valid     = 1'b1;
        grant     = N'(1) << idx_q;
        grant_idx = idx_q;
        if (ready) begin
          if (en && (|req)) begin
            idx_d = win;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Randomised and directed checks of prio_arbiter (N=4) against a cycle-level reference model.
module tb_prio_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [N-1:0] req;
  logic         ready;
  logic         valid;
  logic [N-1:0] grant;
  logic [W-1:0] grant_idx;
  logic         fsm_state;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: whether a grant is presented, its index, and the rotating start point.
  bit m_valid;
  int m_idx;
  int m_ptr;

  prio_arbiter #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .ready     (ready),
    .valid     (valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r);
`ifdef PRIO_ARB_RR_EN
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr - k + N) % N;
      if (((r >> j) & 4'd1) != 4'd0) return j;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (((r >> i) & 4'd1) != 4'd0) return i;
    end
`endif
    return 0;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = N - 1;
  endfunction

  function automatic void model_update();
    int old_idx;
    bit hs;
    old_idx = m_idx;
    hs      = m_valid && ready;
    if (!m_valid || ready) begin
      if (en && req != 4'd0) begin
        m_idx   = pick(req);
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
        m_idx   = 0;
      end
    end
    if (hs) m_ptr = (old_idx == 0) ? N - 1 : old_idx - 1;
  endfunction

  // Advance one clock: the model sees the same inputs as the DUT, then outputs settle.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    req   = 4'b1111;
    ready = 1'b1;
    #12;
    vectors++;
    if (valid !== 1'b0 || grant !== 4'd0 || grant_idx !== 2'd0 || fsm_state !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b grant=%b idx=%0d state=%b, expected all zero",
               valid, grant, grant_idx, fsm_state);
    end
    @(posedge clk);
    #1;
    en    = 1'b0;
    req   = 4'd0;
    ready = 1'b0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    en    = 1'b1;
    req   = 4'b0101;
    ready = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b1 || grant !== 4'b0100 || grant_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL first_grant: valid=%b grant=%b idx=%0d, expected valid=1 grant=0100 idx=2",
               valid, grant, grant_idx);
    end
  endtask

  task automatic test_sticky();
    ready = 1'b0;
    req   = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      en = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if (valid !== 1'b1 || grant !== 4'b0100 || grant_idx !== 2'd2) begin
        miscompares++;
        $display("FAIL sticky_grant cyc %0d: valid=%b grant=%b idx=%0d, expected valid=1 grant=0100 idx=2",
                 c, valid, grant, grant_idx);
      end
    end
  endtask

  task automatic test_back_to_back();
`ifdef PRIO_ARB_RR_EN
    logic [N-1:0] seq[$];
    logic [N-1:0] exp_seq[5];
`endif
    pulse_reset();
    en    = 1'b1;
    req   = 4'b1111;
    ready = 1'b1;
`ifdef PRIO_ARB_RR_EN
    exp_seq = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    for (int c = 0; c < 9; c++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || grant !== (4'd1 << m_idx)) begin
        miscompares++;
        $display("FAIL rr_b2b cyc %0d: valid=%b grant=%b, expected valid=1 grant=%b",
                 c, valid, grant, 4'd1 << m_idx);
      end
      if (seq.size() == 0 || seq[$] != grant) seq.push_back(grant);
    end
    vectors++;
    if (seq.size() < 5) begin
      miscompares++;
      $display("FAIL rr_order: %0d distinct grants seen, expected at least 5", seq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (seq[i] !== exp_seq[i]) begin
          miscompares++;
          $display("FAIL rr_order pos %0d: grant=%b, expected %b", i, seq[i], exp_seq[i]);
          break;
        end
      end
    end
`else
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++;
      if (valid !== 1'b1 || grant !== 4'b1000 || grant_idx !== 2'd3) begin
        miscompares++;
        $display("FAIL fixed_b2b cyc %0d: valid=%b grant=%b idx=%0d, expected valid=1 grant=1000 idx=3",
                 c, valid, grant, grant_idx);
      end
    end
`endif
  endtask

  task automatic test_enable();
    pulse_reset();
    en  = 1'b0;
    req = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      ready = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if (valid !== 1'b0 || grant !== 4'd0 || grant_idx !== 2'd0) begin
        miscompares++;
        $display("FAIL enable_low cyc %0d: valid=%b grant=%b idx=%0d, expected all zero",
                 c, valid, grant, grant_idx);
      end
    end
    en    = 1'b1;
    ready = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b1 || grant !== 4'b0010 || grant_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL enable_rise: valid=%b grant=%b idx=%0d, expected valid=1 grant=0010 idx=1",
               valid, grant, grant_idx);
    end
  endtask

  task automatic test_async_reset();
    en    = 1'b1;
    req   = 4'b0010;
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b1 || grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL pre_reset_hold: valid=%b grant=%b, expected valid=1 grant=0010", valid, grant);
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (valid !== 1'b0 || grant !== 4'd0 || grant_idx !== 2'd0 || fsm_state !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b grant=%b idx=%0d state=%b, expected all zero",
               valid, grant, grant_idx, fsm_state);
    end
`ifdef PRIO_ARB_RR_EN
    vectors++;
    if (dut.ptr !== 2'd3) begin
      miscompares++;
      $display("FAIL async_reset_ptr: ptr=%0d, expected 3", dut.ptr);
    end
`endif
    #1;
    reset = 1'b0;
    model_reset();
    en  = 1'b0;
    req = 4'b0110;
    step();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: valid=%b, expected 0", valid);
    end
    en = 1'b1;
    step();
    vectors++;
    if (valid !== 1'b1 || grant !== 4'b0100 || grant_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL post_reset_first: valid=%b grant=%b idx=%0d, expected valid=1 grant=0100 idx=2",
               valid, grant, grant_idx);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_grant;
    for (int c = 0; c < 400; c++) begin
      req   = 4'($urandom_range(0, 15));
      en    = ($urandom_range(0, 3) != 0);
      ready = 1'($urandom_range(0, 1));
      step();
      exp_grant = m_valid ? (4'd1 << m_idx) : 4'd0;
      vectors++;
      if (valid !== m_valid || grant !== exp_grant || grant_idx !== 2'(m_idx) || fsm_state !== m_valid) begin
        miscompares++;
        $display("FAIL random cyc %0d: valid=%b grant=%b idx=%0d state=%b, expected valid=%b grant=%b idx=%0d",
                 c, valid, grant, grant_idx, fsm_state, m_valid, exp_grant, m_idx);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_sticky();
    test_back_to_back();
    test_enable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the number of request channels (legal range 2..32).
REQ-002 The block SHALL have derived parameter W = $clog2(N), default 3, meaning the grant index width.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is an asynchronous, active-high reset.
REQ-005 Port en, input, 1, is the arbitration enable; while low, no new grant is loaded.
REQ-006 Port req, input, N, is the per-channel request vector; bit i high means channel i is requesting.
REQ-007 Port ready, input, 1, is the consumer acceptance of the current grant.
REQ-008 Port valid, output, 1, is high while a grant is presented.
REQ-009 Port grant, output, N, is the one-hot grant vector; it is all-zero whenever valid is low.
REQ-010 Port grant_idx, output, W, is the binary index of the granted channel; it is 0 whenever valid is low.

Function
REQ-011 The FSM SHALL have two states: IDLE (valid=0) and HOLD (valid=1).
REQ-012 In IDLE, when en=1 and req!=0 at a rising edge, the block SHALL register the winner, enter HOLD and assert valid on the following cycle (1-cycle latency).
REQ-013 In IDLE, when en=0 or req=0, the block SHALL remain in IDLE with all outputs zero.
REQ-014 In HOLD without ready, grant, grant_idx and valid SHALL hold stable regardless of changes on req or en (sticky grant).
REQ-015 In HOLD with ready=1 at an edge (handshake), if en=1 and req!=0, the block SHALL load the next winner on that same edge and stay in HOLD (back-to-back, no bubble).
REQ-016 In HOLD with ready=1 at an edge, if en=0 or req=0, the block SHALL return to IDLE and drive valid=0 on the next cycle.
REQ-017 The winner evaluated at a handshake edge SHALL use the pointer value before that handshake's update.
REQ-018 Fixed-priority selection SHALL choose the highest-index set bit of req.
REQ-019 grant SHALL always equal (1 << grant_idx) when valid=1; exactly one bit is set.
REQ-020 ready while in IDLE SHALL be ignored.

Reset
REQ-021 Asserting reset SHALL immediately (asynchronously) force state=IDLE, valid=0, grant=0 and grant_idx=0, including mid-HOLD; any pending grant is discarded.
REQ-022 Reset SHALL set the round-robin pointer (when present) to N-1.
REQ-023 After reset deasserts, the first arbitration SHALL occur on the first rising edge at which en=1 and req!=0.

Configuration
REQ-024 Macro PRIO_ARB_RR_EN SHALL select the arbitration mode at compile time.
REQ-025 Without PRIO_ARB_RR_EN, selection SHALL be fixed priority per REQ-018, and no pointer register SHALL exist.
REQ-026 With PRIO_ARB_RR_EN, a W-bit pointer ptr SHALL exist; the search SHALL begin at index ptr and descend with wrap (ptr, ptr-1, ..., 0, N-1, ...); the first set bit found wins.
REQ-027 With PRIO_ARB_RR_EN, on each handshake of index k, ptr SHALL update to k-1, and to N-1 when k=0; ptr SHALL be unchanged otherwise.
REQ-028 With PRIO_ARB_RR_EN and ptr at its reset value, the first grant SHALL equal the fixed-priority result.

Verification (N=4)
REQ-029 The bench SHALL check: reset, en=1, req=0101 -> one cycle later valid=1, grant=0100, grant_idx=2.
REQ-030 The bench SHALL check: HOLD with grant=0100, ready=0 for 5 cycles while req changes to 1000 -> grant stays 0100 throughout.
REQ-031 The bench SHALL check (fixed mode): req=1111 held, ready=1 continuously -> grant=1000 every cycle, with valid never dropping.
REQ-032 The bench SHALL check (RR mode): req=1111 held, ready=1 continuously -> grant sequence 1000, 0100, 0010, 0001, 1000, covering pointer wrap.
REQ-033 The bench SHALL check: en=0 with req=0011 -> valid stays 0; then set en=1 -> next cycle grant=0010, grant_idx=1.
REQ-034 The bench SHALL check: in HOLD, assert reset asynchronously between edges -> valid, grant and grant_idx are 0 before the next edge, and RR ptr=3.
